// File: rtl/pc_unit_if.sv
// Fetch-side bus of the program-counter unit: redirect controls in,
// fetch address, redirect flag and return-stack status out.
interface pc_unit_if #(
  parameter int ADDR_W = 32
);
  logic              stall;
  logic              branch_taken;
  logic [15:0]       branch_off;
  logic              jump;
  logic [25:0]       jump_idx;
  logic              jr;
  logic [ADDR_W-1:0] jr_target;
  logic              call;
  logic              ret;
  logic              exc;
  logic [ADDR_W-1:0] pc_out;
  logic [ADDR_W-1:0] pc_plus4;
  logic              redirect;
  logic              ras_empty;
  logic              ras_full;

  modport master (
    output stall, branch_taken, branch_off,
    output jump, jump_idx, jr, jr_target,
    output call, ret, exc,
    input  pc_out, pc_plus4, redirect,
    input  ras_empty, ras_full
  );

  modport slave (
    input  stall, branch_taken, branch_off,
    input  jump, jump_idx, jr, jr_target,
    input  call, ret, exc,
    output pc_out, pc_plus4, redirect,
    output ras_empty, ras_full
  );
endinterface

// File: rtl/pc_unit.sv
// Mini-MIPS fetch program counter with prioritised next-PC selection
// and a circular return-address stack for call/return prediction.
module pc_unit #(
  parameter int ADDR_W = 32,
  parameter logic [ADDR_W-1:0] RESET_VECTOR = '0,
  parameter logic [ADDR_W-1:0] EXC_VECTOR = ADDR_W'(32'h8000_0180),
  parameter int RAS_DEPTH = 4
) (
  input logic       clk,
  input logic       rst,
  pc_unit_if.slave  bus
);

  localparam int PW = (RAS_DEPTH > 1) ? $clog2(RAS_DEPTH) : 1;
  localparam int CW = PW + 1;

  typedef enum logic [2:0] {
    S_SEQ, S_EXC, S_HOLD, S_JR, S_RAS, S_JMP, S_BR
  } src_e;

  logic [ADDR_W-1:0] pc;
  logic [ADDR_W-1:0] pc_p4;
  logic [ADDR_W-1:0] pc_nxt;
  logic [ADDR_W-1:0] br_tgt;
  logic [ADDR_W-1:0] jmp_tgt;
  logic [ADDR_W-1:0] ras_mem [RAS_DEPTH];
  logic [ADDR_W-1:0] ras_top;
  logic [PW-1:0]     top;
  logic [PW-1:0]     top_m1;
  logic [CW-1:0]     cnt;
  logic              empty;
  logic              full;
  logic              advance;
  logic              push;
  logic              pop;
  logic              redirect;
  src_e              src;

  assign pc_p4   = pc + ADDR_W'(4);
  assign br_tgt  = pc_p4 + {{(ADDR_W-18){bus.branch_off[15]}},
                            bus.branch_off, 2'b00};
  assign top_m1  = top - PW'(1);
  assign ras_top = ras_mem[top_m1];
  assign empty   = (cnt == '0);
  assign full    = (cnt == CW'(RAS_DEPTH));

  // Keep the upper region bits of pc+4; low 28 bits come from the index.
  always_comb begin
    jmp_tgt       = pc_p4;
    jmp_tgt[27:0] = {bus.jump_idx, 2'b00};
  end

  always_comb begin
    src = S_SEQ;
    if (bus.exc)               src = S_EXC;
    else if (bus.stall)        src = S_HOLD;
    else if (bus.jr)           src = (bus.ret && !empty) ? S_RAS : S_JR;
    else if (bus.jump)         src = S_JMP;
    else if (bus.branch_taken) src = S_BR;
  end

  always_comb begin
    unique case (src)
      S_EXC:   pc_nxt = EXC_VECTOR;
      S_HOLD:  pc_nxt = pc;
      S_RAS:   pc_nxt = ras_top;
      S_JR:    pc_nxt = bus.jr_target;
      S_JMP:   pc_nxt = jmp_tgt;
      S_BR:    pc_nxt = br_tgt;
      default: pc_nxt = pc_p4;
    endcase
  end

  assign advance = !bus.exc && !bus.stall;
  assign push    = advance && bus.call;
  assign pop     = advance && (src == S_RAS);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      pc       <= RESET_VECTOR;
      redirect <= 1'b0;
      top      <= '0;
      cnt      <= '0;
    end else begin
      pc       <= pc_nxt;
      redirect <= (src != S_SEQ) && (src != S_HOLD);
      if (push && !pop) begin
        top <= top + PW'(1);
        if (!full) cnt <= cnt + CW'(1);
      end else if (pop && !push) begin
        top <= top_m1;
        cnt <= cnt - CW'(1);
      end
    end
  end

  // Combined call+return rewrites the current top in place.
  always_ff @(posedge clk) begin
    if (push) ras_mem[pop ? top_m1 : top] <= pc_p4;
  end

  assign bus.pc_out    = pc;
  assign bus.pc_plus4  = pc_p4;
  assign bus.redirect  = redirect;
  assign bus.ras_empty = empty;
  assign bus.ras_full  = full;

endmodule

// File: tb/tb_pc_unit.sv
// Directed bench for pc_unit: sequential fetch, branch, jump, stall,
// return-stack behaviour, exception priority and asynchronous reset.
module tb_pc_unit;

  logic clk;
  logic rst;
  int   n_cmp;
  int   n_bad;

  pc_unit_if #(.ADDR_W(32)) bus ();

  pc_unit dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got,
                       input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic idle();
    bus.stall        = 1'b0;
    bus.branch_taken = 1'b0;
    bus.branch_off   = '0;
    bus.jump         = 1'b0;
    bus.jump_idx     = '0;
    bus.jr           = 1'b0;
    bus.jr_target    = '0;
    bus.call         = 1'b0;
    bus.ret          = 1'b0;
    bus.exc          = 1'b0;
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic go_to(input logic [31:0] a);
    idle();
    bus.jr        = 1'b1;
    bus.jr_target = a;
    tick();
    idle();
  endtask

  task automatic call_at(input logic [31:0] a);
    go_to(a);
    bus.jump     = 1'b1;
    bus.jump_idx = 26'h400;
    bus.call     = 1'b1;
    tick();
    idle();
  endtask

  task automatic do_ret(input logic [31:0] t);
    idle();
    bus.jr        = 1'b1;
    bus.ret       = 1'b1;
    bus.jr_target = t;
    tick();
    idle();
  endtask

  initial begin
    n_cmp = 0;
    n_bad = 0;
    idle();
    rst = 1'b1;
    tick();
    tick();
    check("rst_pc", bus.pc_out, 32'h0);
    check("rst_redir", {31'b0, bus.redirect}, 32'h0);
    check("rst_empty", {31'b0, bus.ras_empty}, 32'h1);
    check("rst_full", {31'b0, bus.ras_full}, 32'h0);
    rst = 1'b0;
    check("rel_pc0", bus.pc_out, 32'h0);
    for (int i = 1; i <= 3; i++) begin
      tick();
      check("seq_pc", bus.pc_out, 32'(i * 4));
      check("seq_redir", {31'b0, bus.redirect}, 32'h0);
    end
    check("seq_empty", {31'b0, bus.ras_empty}, 32'h1);

    go_to(32'h100);
    check("jr_pc", bus.pc_out, 32'h100);
    check("jr_redir", {31'b0, bus.redirect}, 32'h1);
    bus.branch_taken = 1'b1;
    bus.branch_off   = 16'hFFFE;
    tick();
    idle();
    check("br_back", bus.pc_out, 32'h0FC);
    check("br_redir", {31'b0, bus.redirect}, 32'h1);
    tick();
    check("br_seq", bus.pc_out, 32'h100);
    check("br_redir0", {31'b0, bus.redirect}, 32'h0);
    bus.branch_taken = 1'b1;
    bus.branch_off   = 16'h0003;
    tick();
    idle();
    check("br_fwd", bus.pc_out, 32'h110);

    go_to(32'h0040_0010);
    bus.jump     = 1'b1;
    bus.jump_idx = 26'h0100040;
    tick();
    idle();
    check("jmp_pc", bus.pc_out, 32'h0040_0100);
    check("jmp_redir", {31'b0, bus.redirect}, 32'h1);
    bus.stall = 1'b1;
    for (int i = 0; i < 3; i++) begin
      tick();
      check("stall_pc", bus.pc_out, 32'h0040_0100);
      check("stall_redir", {31'b0, bus.redirect}, 32'h0);
    end
    idle();

    go_to(32'h3000_0000);
    bus.jump         = 1'b1;
    bus.jump_idx     = 26'h0000010;
    bus.branch_taken = 1'b1;
    bus.branch_off   = 16'h0100;
    tick();
    idle();
    check("jmp_over_br", bus.pc_out, 32'h3000_0040);

    go_to(32'hFFFF_FFFC);
    tick();
    check("wrap", bus.pc_out, 32'h0);

    go_to(32'h200);
    bus.jump     = 1'b1;
    bus.jump_idx = 26'h100;
    bus.call     = 1'b1;
    tick();
    idle();
    check("call_pc", bus.pc_out, 32'h400);
    check("call_nempty", {31'b0, bus.ras_empty}, 32'h0);
    do_ret(32'hDEAD_BEE0);
    check("ret_pc", bus.pc_out, 32'h204);
    check("ret_empty", {31'b0, bus.ras_empty}, 32'h1);
    do_ret(32'hDEAD_BEE0);
    check("ret_nopop", bus.pc_out, 32'hDEAD_BEE0);

    for (int i = 1; i <= 5; i++) call_at(32'(i * 16));
    check("ovf_full", {31'b0, bus.ras_full}, 32'h1);
    do_ret(32'hCAFE_0000);
    check("ovf_r1", bus.pc_out, 32'h54);
    check("ovf_nfull", {31'b0, bus.ras_full}, 32'h0);
    do_ret(32'hCAFE_0000);
    check("ovf_r2", bus.pc_out, 32'h44);
    do_ret(32'hCAFE_0000);
    check("ovf_r3", bus.pc_out, 32'h34);
    do_ret(32'hCAFE_0000);
    check("ovf_r4", bus.pc_out, 32'h24);
    check("ovf_empty", {31'b0, bus.ras_empty}, 32'h1);
    do_ret(32'hCAFE_0000);
    check("ovf_r5", bus.pc_out, 32'hCAFE_0000);

    call_at(32'h300);
    call_at(32'h500);
    bus.jr        = 1'b1;
    bus.ret       = 1'b1;
    bus.call      = 1'b1;
    bus.jr_target = 32'h1;
    tick();
    idle();
    check("callret_pc", bus.pc_out, 32'h504);
    do_ret(32'h1);
    check("callret_top", bus.pc_out, 32'h1004);
    do_ret(32'h1);
    check("callret_old", bus.pc_out, 32'h304);
    check("callret_empty", {31'b0, bus.ras_empty}, 32'h1);

    call_at(32'h300);
    bus.exc      = 1'b1;
    bus.stall    = 1'b1;
    bus.jump     = 1'b1;
    bus.jump_idx = 26'h200;
    bus.call     = 1'b1;
    tick();
    idle();
    check("exc_pc", bus.pc_out, 32'h8000_0180);
    check("exc_redir", {31'b0, bus.redirect}, 32'h1);
    check("exc_nempty", {31'b0, bus.ras_empty}, 32'h0);
    do_ret(32'h1);
    check("exc_ras", bus.pc_out, 32'h304);
    check("exc_cnt", {31'b0, bus.ras_empty}, 32'h1);

    call_at(32'h600);
    bus.jr        = 1'b1;
    bus.jr_target = 32'h700;
    tick();
    check("pre_arst_redir", {31'b0, bus.redirect}, 32'h1);
    rst = 1'b1;
    #2;
    check("arst_pc", bus.pc_out, 32'h0);
    check("arst_redir", {31'b0, bus.redirect}, 32'h0);
    check("arst_empty", {31'b0, bus.ras_empty}, 32'h1);
    idle();
    tick();
    rst = 1'b0;
    tick();
    check("post_arst", bus.pc_out, 32'h4);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
